// File: rtl/pixel_pkg.sv
// Shared types for the pixel clip/write path: signed coordinates, pixel record, address sizing.
package pixel_pkg;
    localparam int COORD_W = 32;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t      x;
        coord_t      y;
        logic [7:0]  color;
    } pixel_t;

    // Minimum address width able to cover n_pixels linear locations.
    function automatic int addr_width(input int n_pixels);
        return (n_pixels <= 1) ? 1 : $clog2(n_pixels);
    endfunction
endpackage

// File: rtl/pixel_clip_writer_if.sv
// Pixel stream in from the shape generator plus the memory write port out.
interface pixel_clip_writer_if #(
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = 16
);
    import pixel_pkg::*;

    coord_t               _in0;
    coord_t               _in1;
    logic [COLOR_W-1:0]   _in_color;
    logic                 _in_valid;
    logic                 _in_ready;
    logic                 _in_done;
    logic [ADDR_W-1:0]    mem_addr;
    logic [COLOR_W-1:0]   mem_data;
    logic                 mem_we;
    logic                 mem_ready;

    modport master (
        output _in0, _in1, _in_color, _in_valid, _in_done, mem_ready,
        input  _in_ready, mem_addr, mem_data, mem_we
    );

    modport slave (
        input  _in0, _in1, _in_color, _in_valid, _in_done, mem_ready,
        output _in_ready, mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/pixel_fifo.sv
// Generic first-word-fall-through FIFO, DEPTH a power of two.
// Latency: pushed word visible on pop_dat the cycle after the push.
// Backpressure: push at full only lands when a pop happens in the same cycle.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   _clock,
    input  logic                   _start,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge _clock) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge _clock) begin
        if (_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_clip_writer.sv
// Clips/dedups generator pixels, linearises to a framebuffer address, writes them to memory.
// Latency: accepted pixel reaches mem_we 2 cycles later at the earliest.
// Backpressure: _in_ready drops when S1 plus FIFO occupancy reaches DEPTH; mem_ready stalls the head.
module pixel_clip_writer
    import pixel_pkg::*;
#(
    parameter int FB_WIDTH  = 16,
    parameter int FB_HEIGHT = 12,
    parameter int ADDR_W    = 16,
    parameter int COLOR_W   = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 _clock,
    input  logic                 _start,
    pixel_clip_writer_if.slave   px,
    output logic [31:0]          pixel_count,
    output logic [31:0]          clip_count,
    output logic                 _done
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = ADDR_W + COLOR_W;

    logic               s1_vld;
    logic [ADDR_W-1:0]  s1_addr;
    logic [COLOR_W-1:0] s1_color;
    logic               last_vld;
    coord_t             last_x;
    coord_t             last_y;
    logic               done_seen;

    logic               accept;
    logic               in_range;
    logic               dup;
    logic [CW:0]        occ;

    logic [FW-1:0]      head_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               pop;

    assign in_range = (px._in0 >= 0) && (px._in0 < FB_WIDTH) &&
                      (px._in1 >= 0) && (px._in1 < FB_HEIGHT);
    assign dup      = last_vld && (px._in0 == last_x) && (px._in1 == last_y);
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, s1_vld};

    // S1 counts as occupancy so its unconditional push next cycle always has room.
    assign px._in_ready = !_start && (occ < (CW+1)'(DEPTH));
    assign accept       = px._in_valid && px._in_ready;

    always_ff @(posedge _clock) begin
        if (_start) begin
            s1_vld      <= 1'b0;
            s1_addr     <= '0;
            s1_color    <= '0;
            last_vld    <= 1'b0;
            last_x      <= '0;
            last_y      <= '0;
            clip_count  <= '0;
            pixel_count <= '0;
            done_seen   <= 1'b0;
            _done       <= 1'b0;
        end else begin
            s1_vld <= 1'b0;
            if (accept) begin
                if (!in_range) begin
                    clip_count <= clip_count + 32'd1;
                end else if (!dup) begin
                    last_vld <= 1'b1;
                    last_x   <= px._in0;
                    last_y   <= px._in1;
                    s1_vld   <= 1'b1;
                    s1_addr  <= ADDR_W'(px._in1 * FB_WIDTH + px._in0);
                    s1_color <= px._in_color;
                end
            end
            if (pop)          pixel_count <= pixel_count + 32'd1;
            if (px._in_done)  done_seen   <= 1'b1;
            if (done_seen && !s1_vld && fifo_empty) _done <= 1'b1;
        end
    end

    pixel_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        ._clock   (_clock),
        ._start   (_start),
        .push     (s1_vld),
        .push_dat ({s1_addr, s1_color}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Head is masked while empty so the bus idles at zero instead of stale storage.
    assign px.mem_we   = !fifo_empty && !_start;
    assign px.mem_addr = fifo_empty ? '0 : head_dat[FW-1:COLOR_W];
    assign px.mem_data = fifo_empty ? '0 : head_dat[COLOR_W-1:0];
    assign pop         = px.mem_we && px.mem_ready;

    // fifo_full is implied by occupancy; kept connected for visibility only.
    logic unused_full;
    assign unused_full = fifo_full;
endmodule
